// File: rtl/ee457_regfile_wb_queue.sv
// Write-side front end of the 2R1W register file: merges the WB-stage write with a
// buffered multi-cycle-unit write stream and exposes a bypass of uncommitted writes.
module ee457_regfile_wb_queue #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 5,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p_wen,
  input  logic [ADDR_SIZE-1:0]     p_wa,
  input  logic [DATA_SIZE-1:0]     p_wdata,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ADDR_SIZE-1:0]     s_wa,
  input  logic [DATA_SIZE-1:0]     s_wdata,
  output logic                     rf_wen,
  output logic [ADDR_SIZE-1:0]     rf_wa,
  output logic [DATA_SIZE-1:0]     rf_wdata,
  input  logic [ADDR_SIZE-1:0]     ra,
  output logic                     ra_hit,
  output logic [DATA_SIZE-1:0]     ra_data,
  input  logic [ADDR_SIZE-1:0]     rb,
  output logic                     rb_hit,
  output logic [DATA_SIZE-1:0]     rb_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]     live_q, live_d;
  logic [ADDR_SIZE-1:0] wa_q    [DEPTH];
  logic [ADDR_SIZE-1:0] wa_d    [DEPTH];
  logic [DATA_SIZE-1:0] wdata_q [DEPTH];
  logic [DATA_SIZE-1:0] wdata_d [DEPTH];

  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;

  logic                 rf_wen_q, rf_wen_d;
  logic [ADDR_SIZE-1:0] rf_wa_q, rf_wa_d;
  logic [DATA_SIZE-1:0] rf_wdata_q, rf_wdata_d;

  logic p_act;
  logic push;
  logic store;
  logic pop;

  assign s_ready  = !rst && (count_q != CW'(DEPTH));
  assign count    = count_q;
  assign rf_wen   = rf_wen_q;
  assign rf_wa    = rf_wa_q;
  assign rf_wdata = rf_wdata_q;

  assign p_act = p_wen && (p_wa != '0);
  assign push  = s_valid && s_ready;
  assign store = push && (s_wa != '0);
  assign pop   = !p_act && (count_q != '0);

  always_comb begin
    live_d     = live_q;
    wa_d       = wa_q;
    wdata_d    = wdata_q;
    head_d     = head_q;
    tail_d     = tail_q;
    rf_wen_d   = rf_wen_q;
    rf_wa_d    = rf_wa_q;
    rf_wdata_d = rf_wdata_q;

    // A primary write is younger than anything queued, so queued writes to its address die.
    for (int i = 0; i < DEPTH; i++) begin
      if (p_act && (wa_q[i] == p_wa)) begin
        live_d[i] = 1'b0;
      end
    end

    // Clearing live on pop keeps free slots invisible to the bypass scan.
    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end

    if (store) begin
      live_d[tail_q]  = !(p_act && (s_wa == p_wa));
      wa_d[tail_q]    = s_wa;
      wdata_d[tail_q] = s_wdata;
      tail_d          = tail_q + 1'b1;
    end

    count_d = count_q + CW'(store) - CW'(pop);

    if (p_act) begin
      rf_wen_d   = 1'b1;
      rf_wa_d    = p_wa;
      rf_wdata_d = p_wdata;
    end else if (pop) begin
      rf_wen_d   = live_q[head_q];
      rf_wa_d    = wa_q[head_q];
      rf_wdata_d = wdata_q[head_q];
    end else begin
      rf_wen_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_wen_q   <= 1'b0;
      rf_wa_q    <= '0;
      rf_wdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wa_q[i]    <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      live_q     <= live_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_wen_q   <= rf_wen_d;
      rf_wa_q    <= rf_wa_d;
      rf_wdata_q <= rf_wdata_d;
      wa_q       <= wa_d;
      wdata_q    <= wdata_d;
    end
  end

  // Scan oldest to youngest so the entry nearest the tail overrides; the output register is lowest priority.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = head_q;
    ra_hit  = 1'b0;
    ra_data = '0;
    rb_hit  = 1'b0;
    rb_data = '0;

    if ((ra != '0) && rf_wen_q && (rf_wa_q == ra)) begin
      ra_hit  = 1'b1;
      ra_data = rf_wdata_q;
    end
    if ((rb != '0) && rf_wen_q && (rf_wa_q == rb)) begin
      rb_hit  = 1'b1;
      rb_data = rf_wdata_q;
    end

    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((ra != '0) && live_q[idx] && (wa_q[idx] == ra)) begin
        ra_hit  = 1'b1;
        ra_data = wdata_q[idx];
      end
      if ((rb != '0) && live_q[idx] && (wa_q[idx] == rb)) begin
        rb_hit  = 1'b1;
        rb_data = wdata_q[idx];
      end
    end
  end

endmodule
